// File: rtl/attn_head_stream.sv
// Streaming single-head attention core: buffers SEQ tokens, projects Q/K/V, then
// emits one ReLU'd, saturated attention output per query over valid/ready.
module attn_head_stream #(
  parameter int DW   = 8,
  parameter int SEQ  = 16,
  parameter int WSH  = 6,
  parameter int SSH  = 6,
  parameter int FRAC = 6,
  localparam int IW  = (SEQ > 1) ? $clog2(SEQ) : 1
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic signed [DW-1:0] in_x,
  input  logic signed [DW-1:0] in_bias,
  input  logic signed [DW-1:0] wq,
  input  logic signed [DW-1:0] wk,
  input  logic signed [DW-1:0] wv,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [DW-1:0]        out_y,
  output logic [IW-1:0]        out_idx,
  output logic                 busy
);

  localparam int PW  = 2*DW;
  localparam int SW  = 2*DW + 1;
  localparam int TW  = FRAC + 2;
  localparam int TVW = TW + DW;
  localparam int AW  = 2*DW + IW + 2;
  localparam logic [IW-1:0]        LAST = IW'(SEQ-1);
  localparam logic signed [SW-1:0] T_HI = SW'(2**FRAC);
  localparam logic signed [SW-1:0] T_LO = -T_HI;

  typedef enum logic [1:0] {IDLE, LOAD, CALC, OUT} state_t;

  function automatic logic signed [DW-1:0] sat_dw(input logic signed [PW-1:0] a);
    if ((&a[PW-1:DW-1]) || !(|a[PW-1:DW-1])) return a[DW-1:0];
    else if (a[PW-1])                          return {1'b1, {(DW-1){1'b0}}};
    else                                       return {1'b0, {(DW-1){1'b1}}};
  endfunction

  function automatic logic signed [DW-1:0] proj(input logic signed [DW-1:0] x,
                                                input logic signed [DW-1:0] w);
    logic signed [PW-1:0] p;
    p = x * w;
    return sat_dw(p >>> WSH);
  endfunction

  function automatic logic signed [TW-1:0] hard_tanh(input logic signed [SW-1:0] s);
    if (s > T_HI)      return T_HI[TW-1:0];
    else if (s < T_LO) return T_LO[TW-1:0];
    else               return s[TW-1:0];
  endfunction

  // Final scaling: ReLU then clamp to the positive DW-bit range.
  function automatic logic [DW-1:0] relu_sat(input logic signed [AW-1:0] a);
    logic signed [AW-1:0] sh;
    sh = a >>> FRAC;
    if (sh[AW-1])            return '0;
    else if (|sh[AW-2:DW-1]) return {1'b0, {(DW-1){1'b1}}};
    else                     return sh[DW-1:0];
  endfunction

  state_t state_q, state_d;
  logic [IW-1:0]        i_q, j_q;
  logic signed [AW-1:0] acc_q;
  logic [DW-1:0]        out_y_q;
  logic [IW-1:0]        out_idx_q;
  logic signed [DW-1:0] wq_r, wk_r, wv_r;
  logic signed [DW-1:0] q_buf [SEQ];
  logic signed [DW-1:0] k_buf [SEQ];
  logic signed [DW-1:0] v_buf [SEQ];
  logic signed [DW-1:0] b_buf [SEQ];

  logic in_fire, out_fire;
  assign in_ready  = (state_q == IDLE) || (state_q == LOAD);
  assign out_valid = (state_q == OUT);
  assign busy      = (state_q != IDLE);
  assign out_y     = out_y_q;
  assign out_idx   = out_idx_q;
  assign in_fire   = in_valid && in_ready;
  assign out_fire  = out_valid && out_ready;

  // Token 0 is projected with the live weights, since they are latched in that same cycle.
  logic signed [DW-1:0] wq_use, wk_use, wv_use;
  logic [IW-1:0]        widx;
  assign wq_use = (state_q == IDLE) ? wq : wq_r;
  assign wk_use = (state_q == IDLE) ? wk : wk_r;
  assign wv_use = (state_q == IDLE) ? wv : wv_r;
  assign widx   = (state_q == IDLE) ? '0 : j_q;

  logic signed [DW-1:0]  q_i, k_j, v_j, b_j;
  logic signed [PW-1:0]  qk, qk_sh;
  logic signed [SW-1:0]  s;
  logic signed [TW-1:0]  t;
  logic signed [TVW-1:0] tv;
  logic signed [AW-1:0]  acc_next;
  assign q_i      = q_buf[i_q];
  assign k_j      = k_buf[j_q];
  assign v_j      = v_buf[j_q];
  assign b_j      = b_buf[j_q];
  assign qk       = q_i * k_j;
  assign qk_sh    = qk >>> SSH;
  assign s        = {qk_sh[PW-1], qk_sh} + {{(SW-DW){b_j[DW-1]}}, b_j};
  assign t        = hard_tanh(s);
  assign tv       = t * v_j;
  assign acc_next = acc_q + {{(AW-TVW){tv[TVW-1]}}, tv};

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (in_fire) state_d = LOAD;
      LOAD: if (in_fire && j_q == LAST) state_d = CALC;
      CALC: if (j_q == LAST) state_d = OUT;
      OUT:  if (out_ready) state_d = (i_q == LAST) ? IDLE : CALC;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= IDLE;
      i_q       <= '0;
      j_q       <= '0;
      acc_q     <= '0;
      out_y_q   <= '0;
      out_idx_q <= '0;
      wq_r      <= '0;
      wk_r      <= '0;
      wv_r      <= '0;
      for (int n = 0; n < SEQ; n++) begin
        q_buf[n] <= '0;
        k_buf[n] <= '0;
        v_buf[n] <= '0;
        b_buf[n] <= '0;
      end
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE, LOAD: if (in_fire) begin
          q_buf[widx] <= proj(in_x, wq_use);
          k_buf[widx] <= proj(in_x, wk_use);
          v_buf[widx] <= proj(in_x, wv_use);
          b_buf[widx] <= in_bias;
          if (state_q == IDLE) begin
            wq_r <= wq;
            wk_r <= wk;
            wv_r <= wv;
            j_q  <= IW'(1);
          end else if (j_q == LAST) begin
            i_q   <= '0;
            j_q   <= '0;
            acc_q <= '0;
          end else begin
            j_q <= j_q + 1'b1;
          end
        end
        CALC: begin
          acc_q <= acc_next;
          if (j_q == LAST) begin
            out_y_q   <= relu_sat(acc_next);
            out_idx_q <= i_q;
            j_q       <= '0;
          end else begin
            j_q <= j_q + 1'b1;
          end
        end
        OUT: if (out_ready && i_q != LAST) begin
          i_q   <= i_q + 1'b1;
          j_q   <= '0;
          acc_q <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_attn_head_stream.sv
// Randomised bench for attn_head_stream (SEQ=4) against a plain-arithmetic attention model.
module tb_attn_head_stream;

  localparam int DW = 8, SEQ = 4, WSH = 6, SSH = 6, FRAC = 6, IW = 2;

  logic                 clk = 1'b0;
  logic                 rstn = 1'b0;
  logic                 in_valid = 1'b0;
  logic                 in_ready;
  logic signed [DW-1:0] in_x = '0, in_bias = '0;
  logic signed [DW-1:0] wq = '0, wk = '0, wv = '0;
  logic                 out_valid;
  logic                 out_ready = 1'b1;
  logic [DW-1:0]        out_y;
  logic [IW-1:0]        out_idx;
  logic                 busy;

  attn_head_stream #(.DW(DW), .SEQ(SEQ), .WSH(WSH), .SSH(SSH), .FRAC(FRAC)) dut (
    .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(in_ready),
    .in_x(in_x), .in_bias(in_bias), .wq(wq), .wk(wk), .wv(wv),
    .out_valid(out_valid), .out_ready(out_ready), .out_y(out_y),
    .out_idx(out_idx), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec = 0, n_bad = 0;
  int tx[SEQ], tbv[SEQ], expy[SEQ];
  int swq, swk, swv;
  int hs_cyc;

  task automatic check(input string tag, input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int clampi(input int a, input int lo, input int hi);
    return (a < lo) ? lo : (a > hi) ? hi : a;
  endfunction

  // Reference: attention output per query from the sampled weights and token values.
  function automatic void build_exp();
    int q[SEQ], k[SEQ], v[SEQ];
    int s, t, acc;
    for (int j = 0; j < SEQ; j++) begin
      q[j] = clampi((tx[j] * swq) >>> WSH, -128, 127);
      k[j] = clampi((tx[j] * swk) >>> WSH, -128, 127);
      v[j] = clampi((tx[j] * swv) >>> WSH, -128, 127);
    end
    for (int i = 0; i < SEQ; i++) begin
      acc = 0;
      for (int j = 0; j < SEQ; j++) begin
        s = ((q[i] * k[j]) >>> SSH) + tbv[j];
        t = clampi(s, -(1 << FRAC), 1 << FRAC);
        acc += t * v[j];
      end
      expy[i] = clampi(acc >>> FRAC, 0, 127);
    end
  endfunction

  task automatic load_seq(input bit chg_wq);
    int k = 0;
    wq = DW'(swq); wk = DW'(swk); wv = DW'(swv);
    while (k < SEQ) begin
      @(negedge clk);
      if (chg_wq && k == 2) wq = '0;
      if ($urandom_range(0, 3) == 0) begin
        in_valid = 1'b0;
        in_x     = DW'($urandom);
      end else begin
        in_valid = 1'b1;
        in_x     = DW'(tx[k]);
        in_bias  = DW'(tbv[k]);
        if (in_ready) begin
          hs_cyc = cyc;
          k++;
        end
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
    wq = DW'($urandom); wk = DW'($urandom); wv = DW'($urandom);
  endtask

  task automatic collect(input bit bp, input int max_n);
    int n = 0, guard = 0, prev_hs;
    prev_hs = hs_cyc;
    while (n < max_n && guard < 40 * (SEQ + 1)) begin
      if (out_valid) begin
        check($sformatf("lat%0d", n), cyc - prev_hs, SEQ + 1);
        check($sformatf("idx%0d", n), int'(out_idx), n);
        check($sformatf("y%0d", n), int'(out_y), expy[n]);
        check($sformatf("in_ready_calc%0d", n), int'(in_ready), 0);
        check($sformatf("busy%0d", n), int'(busy), 1);
        if (bp && n == 1) begin
          out_ready = 1'b0;
          repeat (5) begin
            in_valid = 1'b1;
            in_x     = DW'($urandom);
            @(negedge clk);
            check("bp_valid", int'(out_valid), 1);
            check("bp_y", int'(out_y), expy[1]);
            check("bp_idx", int'(out_idx), 1);
            check("bp_busy_ready", int'({busy, in_ready}), 2);
          end
          out_ready = 1'b1;
        end
        prev_hs = cyc;
        n++;
      end
      in_valid = (n < SEQ) ? 1'($urandom_range(0, 1)) : 1'b0;
      in_x     = DW'($urandom);
      if (n < max_n) begin
        @(negedge clk);
        guard++;
      end
    end
    check("outputs_seen", n, max_n);
    in_valid = 1'b0;
  endtask

  task automatic set_uniform(input int x, input int b, input int w_q, input int w_k, input int w_v);
    for (int j = 0; j < SEQ; j++) begin
      tx[j]  = x;
      tbv[j] = b;
    end
    swq = w_q; swk = w_k; swv = w_v;
    build_exp();
  endtask

  initial begin
    int seen;
    repeat (2) @(negedge clk);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_in_ready", int'(in_ready), 1);
    check("rst_out_y", int'(out_y), 0);
    check("rst_out_idx", int'(out_idx), 0);
    check("rst_busy", int'(busy), 0);
    rstn = 1'b1;

    set_uniform(16, 0, 64, 64, 64);
    check("model_basic", expy[0], 4);
    load_seq(1'b0); collect(1'b0, SEQ);

    set_uniform(127, 0, 64, 64, 64);
    load_seq(1'b0); collect(1'b0, SEQ);

    set_uniform(16, 0, 64, 64, -64);
    load_seq(1'b0); collect(1'b0, SEQ);

    set_uniform(16, 20, 64, 64, 64);
    load_seq(1'b0); collect(1'b0, SEQ);

    // Mid-load wq change must not alter results.
    set_uniform(16, 0, 64, 64, 64);
    load_seq(1'b1); collect(1'b0, SEQ);

    // Backpressure on query 1 with random data.
    for (int j = 0; j < SEQ; j++) begin
      tx[j]  = $urandom_range(0, 255) - 128;
      tbv[j] = $urandom_range(0, 80) - 40;
    end
    swq = $urandom_range(0, 255) - 128;
    swk = $urandom_range(0, 255) - 128;
    swv = $urandom_range(0, 127);
    build_exp();
    load_seq(1'b0); collect(1'b1, SEQ);

    // Asynchronous reset during query 2's computation.
    set_uniform(16, 0, 64, 64, 64);
    load_seq(1'b0); collect(1'b0, 2);
    repeat (3) @(negedge clk);
    check("pre_rst_busy", int'(busy), 1);
    rstn = 1'b0;
    #1;
    check("arst_out_valid", int'(out_valid), 0);
    check("arst_in_ready", int'(in_ready), 1);
    check("arst_out_y", int'(out_y), 0);
    check("arst_out_idx", int'(out_idx), 0);
    check("arst_busy", int'(busy), 0);
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    seen = 0;
    repeat (SEQ + 4) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    check("no_spurious_valid", seen, 0);
    load_seq(1'b0); collect(1'b0, SEQ);

    for (int r = 0; r < 8; r++) begin
      for (int j = 0; j < SEQ; j++) begin
        tx[j]  = $urandom_range(0, 255) - 128;
        tbv[j] = (r < 4) ? $urandom_range(0, 255) - 128 : $urandom_range(0, 30) - 15;
      end
      swq = $urandom_range(0, 255) - 128;
      swk = $urandom_range(0, 255) - 128;
      swv = $urandom_range(0, 255) - 128;
      build_exp();
      load_seq(1'b0); collect(1'b0, SEQ);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, %0d of %0d compares bad", n_bad, n_vec);
    $fatal(1);
  end

endmodule
